// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a single-port, synchronous-read RAM; one access per cycle.
// Optional sticky overflow/underflow flags: define RAM_FIFO_ERR_EN.
module ram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ack,
  input  logic             pop,
  output logic             pop_ack,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
`ifdef RAM_FIFO_ERR_EN
  ,
  input  logic             err_clr,
  output logic             ovf_err,
  output logic             unf_err
`endif
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          prio_q, prio_d;
  logic          pop_valid_q;
  logic          push_req, pop_req;

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_req = push & ~full;
  assign pop_req  = pop & ~empty;

  // prio=0 lets pop win a conflict, prio=1 lets push win
  assign pop_ack  = pop_req & (~push_req | ~prio_q);
  assign push_ack = push_req & (~pop_req | prio_q);

  assign ram_we    = push_ack & rst_n;
  assign ram_addr  = push_ack ? wr_ptr_q : rd_ptr_q;
  assign ram_din   = push_data;
  assign pop_data  = ram_dout;
  assign pop_valid = pop_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;
    if (push_ack) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end else if (pop_ack) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
    if (push_req && pop_req) prio_d = ~prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prio_q      <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prio_q      <= prio_d;
      pop_valid_q <= pop_ack;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic ovf_q, unf_q;

  // a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (push & full)  | (ovf_q & ~err_clr);
      unf_q <= (pop  & empty) | (unf_q & ~err_clr);
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 8x8 sync-read RAM attached.
module tb_ram_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;
  logic             push_ack, pop_ack, pop_valid, full, empty, ram_we;
  logic [WIDTH-1:0] pop_data, ram_din, ram_dout;
  logic [AW:0]      count;
  logic [AW-1:0]    ram_addr;
`ifdef RAM_FIFO_ERR_EN
  logic             err_clr, ovf_err, unf_err;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .push_data(push_data), .push_ack(push_ack),
    .pop(pop), .pop_ack(pop_ack), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_FIFO_ERR_EN
    , .err_clr(err_clr), .ovf_err(ovf_err), .unf_err(unf_err)
`endif
  );

  // RAM model: output is garbage on write cycles
  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= 8'hEE;
    end else begin
      ram_dout      <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d);
    push = 1'b1; push_data = d;
    #1;
    chk("push_ack", push_ack, 1);
    step();
    push = 1'b0;
  endtask

  logic [7:0] exp_pop [0:3];
  logic [7:0] conf_pop [0:5];
  logic [7:0] conf_push[0:5];

  initial begin
    rst_n = 1'b0; push = 1'b1; pop = 1'b0; push_data = 8'h5A;
`ifdef RAM_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    #2;
    chk("rst_we_forced", ram_we, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_pvalid", pop_valid, 0);
    step();
    rst_n = 1'b1; push = 1'b0;
    step();

    // single push then pop
    push = 1'b1; push_data = 8'h11;
    #1;
    chk("p1_ack", push_ack, 1);
    chk("p1_we", ram_we, 1);
    chk("p1_addr", ram_addr, 0);
    chk("p1_din", ram_din, 8'h11);
    step();
    push = 1'b0;
    chk("p1_count", count, 1);
    pop = 1'b1;
    #1;
    chk("pop1_ack", pop_ack, 1);
    chk("pop1_we", ram_we, 0);
    chk("pop1_addr", ram_addr, 0);
    step();
    pop = 1'b0;
    chk("pop1_valid", pop_valid, 1);
    chk("pop1_data", pop_data, 8'h11);
    chk("pop1_empty", empty, 1);
    step();
    chk("idle_pvalid", pop_valid, 0);

    // fill to full, blocked push, drain in order
    for (int i = 1; i <= 8; i++) push1(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    push = 1'b1; push_data = 8'h09;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("full_noack", push_ack, 0);
      chk("full_nowe", ram_we, 0);
      step();
    end
    push = 1'b0;
    chk("full_count_hold", count, 8);
    pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("drain_ack", pop_ack, 1);
      step();
      chk("drain_valid", pop_valid, 1);
      chk("drain_data", pop_data, 32'(i));
    end
    #1;
    chk("drain_empty_noack", pop_ack, 0);
    pop = 1'b0;
    chk("drain_empty", empty, 1);
    step();

    // conflict arbitration at 4 entries
    for (int i = 0; i < 4; i++) push1(8'hA0 + 8'(i));
    push = 1'b1; pop = 1'b1;
    conf_pop  = '{1, 0, 1, 0, 1, 0};
    conf_push = '{0, 1, 0, 1, 0, 1};
    for (int k = 0; k < 6; k++) begin
      push_data = 8'hB0 + 8'(k);
      #1;
      chk("conf_pop_ack", pop_ack, conf_pop[k]);
      chk("conf_push_ack", push_ack, conf_push[k]);
      step();
      chk("conf_count", count, (k % 2 == 0) ? 3 : 4);
      if (k == 0) chk("conf_data0", pop_data, 8'hA0);
      if (k == 2) chk("conf_data2", pop_data, 8'hA1);
      if (k == 4) chk("conf_data4", pop_data, 8'hA2);
    end
    push = 1'b0;
    exp_pop = '{8'hA3, 8'hB1, 8'hB3, 8'hB5};
    for (int i = 0; i < 4; i++) begin
      #1;
      // the conflict after the last push left prio favouring pop
      chk("conf_drain_ack", pop_ack, 1);
      step();
      chk("conf_drain_data", pop_data, exp_pop[i]);
    end
    pop = 1'b0;
    chk("conf_drain_empty", empty, 1);

    // 20 push/pop pairs across pointer wrap
    for (int i = 0; i < 20; i++) begin
      push1(8'(i));
      pop = 1'b1;
      #1;
      chk("wrap_pop_ack", pop_ack, 1);
      step();
      pop = 1'b0;
      chk("wrap_valid", pop_valid, 1);
      chk("wrap_data", pop_data, 32'(i));
    end
    chk("wrap_empty", empty, 1);

    // reset mid-operation
    for (int i = 0; i < 6; i++) push1(8'h60 + 8'(i));
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("mid_count5", count, 5);
    chk("mid_pvalid", pop_valid, 1);
    push = 1'b1; push_data = 8'h77;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pvalid", pop_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_we", ram_we, 0);
    step();
    push = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", empty, 1);

`ifdef RAM_FIFO_ERR_EN
    chk("err_rst_ovf", ovf_err, 0);
    chk("err_rst_unf", unf_err, 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("unf_set", unf_err, 1);
    chk("unf_no_ovf", ovf_err, 0);
    for (int i = 0; i < 8; i++) push1(8'(i));
    push = 1'b1;
    step();
    push = 1'b0;
    chk("ovf_set", ovf_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_ovf", ovf_err, 0);
    chk("clr_unf", unf_err, 0);
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      step();
    end
    err_clr = 1'b1;
    step();
    pop = 1'b0; err_clr = 1'b0;
    chk("clr_vs_set_unf", unf_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
